// File: rtl/exu_dispatch_queue.sv
// In-order dispatch queue between decode and the execution units.
// Buffers decoded ops, issues the head to the channel selected by its group,
// tracks outstanding (issued but uncommitted) ops and holds SYS-class ops
// until everything in flight has committed.
module exu_dispatch_queue #(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned NUM_FU    = 6,
  parameter int unsigned GRP_W     = 3,
  parameter int unsigned INFO_W    = 32,
  parameter int unsigned XLEN      = 32,
  parameter int unsigned SER_GRP   = 5,
  parameter int unsigned MAX_OUTST = 8,
  localparam int unsigned PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CNT_W    = $clog2(DEPTH + 1),
  localparam int unsigned OUT_W    = $clog2(MAX_OUTST + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              dec_valid_i,
  output logic              dec_ready_o,
  input  logic [GRP_W-1:0]  dec_grp_i,
  input  logic [INFO_W-1:0] dec_info_i,
  input  logic [XLEN-1:0]   dec_op1_i,
  input  logic [XLEN-1:0]   dec_op2_i,
  input  logic [XLEN-1:0]   dec_imm_i,
  input  logic [XLEN-1:0]   dec_pc_i,
  output logic [NUM_FU-1:0] fu_valid_o,
  input  logic [NUM_FU-1:0] fu_ready_i,
  output logic [INFO_W-1:0] disp_info_o,
  output logic [XLEN-1:0]   disp_op1_o,
  output logic [XLEN-1:0]   disp_op2_o,
  output logic [XLEN-1:0]   disp_imm_o,
  output logic [XLEN-1:0]   disp_pc_o,
  input  logic              commit_i,
  output logic              illegal_o,
  output logic [OUT_W-1:0]  outst_cnt_o,
  output logic              empty_o
);

  // Payload storage
  logic [GRP_W-1:0]  grp_mem  [DEPTH];
  logic [INFO_W-1:0] info_mem [DEPTH];
  logic [XLEN-1:0]   op1_mem  [DEPTH];
  logic [XLEN-1:0]   op2_mem  [DEPTH];
  logic [XLEN-1:0]   imm_mem  [DEPTH];
  logic [XLEN-1:0]   pc_mem   [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] cnt_q;
  logic [OUT_W-1:0] outst_q;

  logic [GRP_W-1:0] head_grp;
  logic             head_vld;
  logic             head_ill;
  logic             blocked;
  logic             issue_vld;
  logic             issue_hs;
  logic             push;
  logic             pop;

  assign head_grp = grp_mem[rd_ptr_q];
  assign head_vld = (cnt_q != '0);
  assign head_ill = head_vld && (32'(head_grp) >= NUM_FU);

  // SYS-class ops wait for an empty pipeline; everything waits at the outstanding cap.
  assign blocked  = (outst_q == OUT_W'(MAX_OUTST)) ||
                    ((32'(head_grp) == SER_GRP) && (outst_q != '0));

  assign issue_vld = head_vld && !head_ill && !blocked && !flush_i;

  // Decode the head group into a one-hot channel valid
  always_comb begin
    fu_valid_o = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      fu_valid_o[i] = issue_vld && (32'(head_grp) == i);
    end
  end

  assign issue_hs  = |(fu_valid_o & fu_ready_i);
  assign illegal_o = head_ill && !flush_i;
  assign pop       = issue_hs || illegal_o;

  // Ready is held low while reset is asserted, hence the direct use of rst.
  assign dec_ready_o = rst && (cnt_q < CNT_W'(DEPTH)) && !flush_i;
  assign push        = dec_valid_i && dec_ready_o;

  // Payload is zeroed whenever nothing is being offered to a unit
  always_comb begin
    disp_info_o = '0;
    disp_op1_o  = '0;
    disp_op2_o  = '0;
    disp_imm_o  = '0;
    disp_pc_o   = '0;
    if (issue_vld) begin
      disp_info_o = info_mem[rd_ptr_q];
      disp_op1_o  = op1_mem[rd_ptr_q];
      disp_op2_o  = op2_mem[rd_ptr_q];
      disp_imm_o  = imm_mem[rd_ptr_q];
      disp_pc_o   = pc_mem[rd_ptr_q];
    end
  end

  assign outst_cnt_o = outst_q;
  assign empty_o     = (cnt_q == '0);

  // Write accepted decode payload into the tail slot
  always_ff @(posedge clk) begin
    if (push) begin
      grp_mem[wr_ptr_q]  <= dec_grp_i;
      info_mem[wr_ptr_q] <= dec_info_i;
      op1_mem[wr_ptr_q]  <= dec_op1_i;
      op2_mem[wr_ptr_q]  <= dec_op2_i;
      imm_mem[wr_ptr_q]  <= dec_imm_i;
      pc_mem[wr_ptr_q]   <= dec_pc_i;
    end
  end

  // Pointer and occupancy bookkeeping; flush discards all buffered entries
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CNT_W'(1);
        2'b01:   cnt_q <= cnt_q - CNT_W'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Outstanding-op counter; survives flush since issued ops still commit
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      outst_q <= '0;
    end else if (issue_hs && !commit_i) begin
      outst_q <= outst_q + OUT_W'(1);
    end else if (!issue_hs && commit_i && (outst_q != '0)) begin
      outst_q <= outst_q - OUT_W'(1);
    end
  end

endmodule

// File: tb/tb_exu_dispatch_queue.sv
// Self-checking bench for exu_dispatch_queue: directed sequences, a vector
// table of single-op issues, and an in-order payload scoreboard.
module tb_exu_dispatch_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush_i;
  logic        dec_valid_i;
  logic        dec_ready_o;
  logic [2:0]  dec_grp_i;
  logic [31:0] dec_info_i, dec_op1_i, dec_op2_i, dec_imm_i, dec_pc_i;
  logic [5:0]  fu_valid_o;
  logic [5:0]  fu_ready_i;
  logic [31:0] disp_info_o, disp_op1_o, disp_op2_o, disp_imm_o, disp_pc_o;
  logic        commit_i;
  logic        illegal_o;
  logic [3:0]  outst_cnt_o;
  logic        empty_o;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2:0]  grp;
    logic [31:0] info, op1, op2, imm, pc;
  } ent_t;
  ent_t sb[$];

  typedef struct {
    logic [2:0]  grp;
    logic [31:0] op1, op2;
    logic [5:0]  exp_valid;
    logic        exp_ill;
  } vec_t;
  vec_t tbl[8];

  exu_dispatch_queue dut (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (flush_i),
    .dec_valid_i (dec_valid_i),
    .dec_ready_o (dec_ready_o),
    .dec_grp_i   (dec_grp_i),
    .dec_info_i  (dec_info_i),
    .dec_op1_i   (dec_op1_i),
    .dec_op2_i   (dec_op2_i),
    .dec_imm_i   (dec_imm_i),
    .dec_pc_i    (dec_pc_i),
    .fu_valid_o  (fu_valid_o),
    .fu_ready_i  (fu_ready_i),
    .disp_info_o (disp_info_o),
    .disp_op1_o  (disp_op1_o),
    .disp_op2_o  (disp_op2_o),
    .disp_imm_o  (disp_imm_o),
    .disp_pc_o   (disp_pc_o),
    .commit_i    (commit_i),
    .illegal_o   (illegal_o),
    .outst_cnt_o (outst_cnt_o),
    .empty_o     (empty_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [2:0] grp, input logic [31:0] op1, input logic [31:0] op2);
    dec_valid_i = 1'b1;
    dec_grp_i   = grp;
    dec_op1_i   = op1;
    dec_op2_i   = op2;
    dec_info_i  = $urandom;
    dec_imm_i   = $urandom;
    dec_pc_i    = $urandom & 32'hffff_fffc;
    tick();
    dec_valid_i = 1'b0;
  endtask

  task automatic commit_n(input int n);
    commit_i = 1'b1;
    repeat (n) tick();
    commit_i = 1'b0;
  endtask

  // Scoreboard: record accepted legal ops, compare every issue handshake in order
  always @(negedge clk) begin
    if (rst) begin
      if (flush_i) begin
        sb.delete();
      end else begin
        if (|(fu_valid_o & fu_ready_i)) begin
          if (sb.size() == 0) begin
            check("sb_unexpected_issue", 64'(fu_valid_o), 64'd0);
          end else begin
            ent_t e;
            logic [5:0] oh;
            e  = sb.pop_front();
            oh = 6'd1 << e.grp;
            check("sb_channel", 64'(fu_valid_o), 64'(oh));
            check("sb_info", 64'(disp_info_o), 64'(e.info));
            check("sb_op1", 64'(disp_op1_o), 64'(e.op1));
            check("sb_op2", 64'(disp_op2_o), 64'(e.op2));
            check("sb_imm", 64'(disp_imm_o), 64'(e.imm));
            check("sb_pc", 64'(disp_pc_o), 64'(e.pc));
          end
        end
        if (dec_valid_i && dec_ready_o && dec_grp_i < 3'd6) begin
          sb.push_back('{dec_grp_i, dec_info_i, dec_op1_i, dec_op2_i, dec_imm_i, dec_pc_i});
        end
      end
    end
  end

  initial begin
    rst         = 1'b0;
    flush_i     = 1'b0;
    dec_valid_i = 1'b0;
    dec_grp_i   = '0;
    dec_info_i  = '0;
    dec_op1_i   = '0;
    dec_op2_i   = '0;
    dec_imm_i   = '0;
    dec_pc_i    = '0;
    fu_ready_i  = '0;
    commit_i    = 1'b0;

    tbl[0] = '{3'd0, 32'h11, 32'h21, 6'b000001, 1'b0};
    tbl[1] = '{3'd1, 32'h12, 32'h22, 6'b000010, 1'b0};
    tbl[2] = '{3'd2, 32'h13, 32'h23, 6'b000100, 1'b0};
    tbl[3] = '{3'd3, 32'h14, 32'h24, 6'b001000, 1'b0};
    tbl[4] = '{3'd4, 32'h15, 32'h25, 6'b010000, 1'b0};
    tbl[5] = '{3'd5, 32'h16, 32'h26, 6'b100000, 1'b0};
    tbl[6] = '{3'd6, 32'h17, 32'h27, 6'b000000, 1'b1};
    tbl[7] = '{3'd7, 32'h18, 32'h28, 6'b000000, 1'b1};

    // Reset values
    #1;
    check("rst_fu_valid", 64'(fu_valid_o), 64'd0);
    check("rst_illegal", 64'(illegal_o), 64'd0);
    check("rst_disp_op1", 64'(disp_op1_o), 64'd0);
    check("rst_empty", 64'(empty_o), 64'd1);
    check("rst_outst", 64'(outst_cnt_o), 64'd0);
    check("rst_ready_low", 64'(dec_ready_o), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    #1 check("ready_after_rst", 64'(dec_ready_o), 64'd1);

    // Single ALU op: issues the cycle after push
    fu_ready_i = 6'b111111;
    push(3'd0, 32'd5, 32'd7);
    check("alu_valid", 64'(fu_valid_o), 64'b000001);
    check("alu_op1", 64'(disp_op1_o), 64'd5);
    check("alu_op2", 64'(disp_op2_o), 64'd7);
    tick();
    check("alu_outst", 64'(outst_cnt_o), 64'd1);
    commit_n(1);
    check("alu_commit", 64'(outst_cnt_o), 64'd0);

    // Fill to full, refuse a 5th, then drain in order
    fu_ready_i = '0;
    push(3'd0, 32'ha0, 32'hb0);
    push(3'd1, 32'ha1, 32'hb1);
    push(3'd2, 32'ha2, 32'hb2);
    push(3'd3, 32'ha3, 32'hb3);
    check("full_ready", 64'(dec_ready_o), 64'd0);
    check("full_head", 64'(fu_valid_o), 64'b000001);
    push(3'd1, 32'hdead, 32'hbeef);
    check("full_held", 64'(fu_valid_o), 64'b000001);
    fu_ready_i = 6'b111111;
    tick();
    check("drain_ready", 64'(dec_ready_o), 64'd1);
    check("drain_1", 64'(fu_valid_o), 64'b000010);
    tick();
    check("drain_2", 64'(fu_valid_o), 64'b000100);
    tick();
    check("drain_3", 64'(fu_valid_o), 64'b001000);
    tick();
    check("drain_empty", 64'(empty_o), 64'd1);
    check("drain_outst", 64'(outst_cnt_o), 64'd4);
    commit_n(4);

    // SYS waits for outstanding MEM ops to commit
    push(3'd4, 32'h40, 32'h41);
    push(3'd4, 32'h42, 32'h43);
    push(3'd5, 32'h50, 32'h51);
    check("sys_outst", 64'(outst_cnt_o), 64'd2);
    check("sys_blocked0", 64'(fu_valid_o), 64'd0);
    check("sys_disp_zero", 64'(disp_op1_o), 64'd0);
    tick();
    check("sys_blocked1", 64'(fu_valid_o), 64'd0);
    commit_n(1);
    check("sys_blocked2", 64'(fu_valid_o), 64'd0);
    commit_n(1);
    check("sys_release", 64'(fu_valid_o), 64'b100000);
    tick();
    check("sys_outst_issue", 64'(outst_cnt_o), 64'd1);
    commit_n(1);

    // Illegal group dropped for one cycle, next entry follows
    push(3'd7, 32'h70, 32'h71);
    check("ill_flag", 64'(illegal_o), 64'd1);
    check("ill_valid", 64'(fu_valid_o), 64'd0);
    push(3'd0, 32'h80, 32'h81);
    check("ill_flag_clr", 64'(illegal_o), 64'd0);
    check("ill_next", 64'(fu_valid_o), 64'b000001);
    check("ill_outst", 64'(outst_cnt_o), 64'd0);
    tick();
    commit_n(1);

    // Flush overrides a ready channel
    fu_ready_i = '0;
    push(3'd0, 32'h90, 32'h91);
    push(3'd1, 32'h92, 32'h93);
    push(3'd2, 32'h94, 32'h95);
    check("flush_pre", 64'(fu_valid_o), 64'b000001);
    flush_i    = 1'b1;
    fu_ready_i = 6'b111111;
    #1;
    check("flush_valid", 64'(fu_valid_o), 64'd0);
    check("flush_ready", 64'(dec_ready_o), 64'd0);
    tick();
    flush_i = 1'b0;
    #1;
    check("flush_empty", 64'(empty_o), 64'd1);
    check("flush_outst", 64'(outst_cnt_o), 64'd0);
    check("flush_post_valid", 64'(fu_valid_o), 64'd0);

    // Issue and commit together; then saturate at MAX_OUTST
    repeat (4) push(3'd0, $urandom, $urandom);
    check("sim_outst3", 64'(outst_cnt_o), 64'd3);
    commit_n(1);
    check("sim_hold3", 64'(outst_cnt_o), 64'd3);
    check("sim_empty", 64'(empty_o), 64'd1);
    repeat (6) push(3'd1, $urandom, $urandom);
    check("max_outst", 64'(outst_cnt_o), 64'd8);
    check("max_blocked", 64'(fu_valid_o), 64'd0);
    tick();
    check("max_still", 64'(fu_valid_o), 64'd0);
    commit_n(1);
    check("max_release", 64'(fu_valid_o), 64'b000010);
    tick();
    check("max_again", 64'(outst_cnt_o), 64'd8);
    commit_n(8);
    check("max_drained", 64'(outst_cnt_o), 64'd0);
    commit_n(1);
    check("commit_underflow", 64'(outst_cnt_o), 64'd0);

    // Vector table: one op per vector into an empty queue
    for (int i = 0; i < 8; i++) begin
      push(tbl[i].grp, tbl[i].op1, tbl[i].op2);
      check($sformatf("vec%0d_valid", i), 64'(fu_valid_o), 64'(tbl[i].exp_valid));
      check($sformatf("vec%0d_illegal", i), 64'(illegal_o), 64'(tbl[i].exp_ill));
      check($sformatf("vec%0d_op1", i), 64'(disp_op1_o),
            (tbl[i].exp_valid != 0) ? 64'(tbl[i].op1) : 64'd0);
      tick();
      if (tbl[i].exp_valid != 0) commit_n(1);
      check($sformatf("vec%0d_empty", i), 64'(empty_o), 64'd1);
      check($sformatf("vec%0d_outst", i), 64'(outst_cnt_o), 64'd0);
    end

    tick();
    check("sb_drained", 64'(sb.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
